pio_phasor_out_commit: RTL
==========================

Name: pio_phasor_out_commit

Overview:
- Avalon-MM slave output PIO that carries data from the HPS to the fabric; it is the write-side counterpart of the existing input PIOs (e.g. the phasor cos read-back ports).
- HPS writes a WIDTH-bit value into a staging register and commits it to out_port.
- Each commit is presented to the downstream consumer (Lorenz/phasor datapath) with a valid/ready handshake and overrun detection.
- Sits in Computer_System between the lightweight HPS bridge and the solver parameter inputs.

Parameters:
- WIDTH, 20, data width of the staging and output registers (1..32).
- RESET_VALUE, 0, value of the staging register and out_port after reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- address  input  2  Avalon register select.
- chipselect  input  1  Avalon select; qualifies read and write.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, registered.
- out_port  output  WIDTH  committed value to the fabric.
- out_valid  output  1  committed value not yet accepted.
- out_ready  input  1  consumer accepts out_port when out_valid=1.

Behaviour:
- Reset: reset_n=0 sampled at a clk edge forces the following on that edge; takes priority over any concurrent access:
  - staging=RESET_VALUE, out_port=RESET_VALUE;
  - out_valid=0, auto=0, overrun=0, readdata=0;
  - FSM to IDLE.
- Register map (wr = chipselect & ~write_n):
  - addr 0 DATA: write stores writedata[WIDTH-1:0] into staging; read returns zero-extended staging.
  - addr 1 CTRL: write bit0=1 issues a commit (self-clearing, reads 0); bit1 sets auto. Read returns {30'b0, auto, 1'b0}.
  - addr 2 STATUS: read returns {30'b0, overrun, out_valid}. Write with bit1=1 clears overrun; bit0 ignored.
  - addr 3 OUT: read-only readback of zero-extended out_port; writes ignored.
- readdata is updated every cycle from address, with no chipselect gating, so it is valid 1 cycle after address is presented. No waitrequest; writes take effect on the same edge.
- Commit sources, one per cycle:
  - CTRL write with bit0=1;
  - DATA write while auto=1. This commit uses the new writedata value, not the old staging.
- On commit: out_port <= commit value, out_valid <= 1.
- FSM:
  - IDLE (out_valid=0): commit -> PEND.
  - PEND (out_valid=1):
    - out_ready=1 and no commit -> IDLE, out_valid=0 next cycle.
    - out_ready=1 and commit -> stay PEND; out_port takes the new value; overrun unchanged (previous value was accepted).
    - out_ready=0 and commit -> stay PEND; out_port takes the newest value; overrun <= 1 (sticky; the dropped value is lost).
    - out_ready=0 and no commit -> hold; out_port stable.
- out_ready while IDLE is ignored.
- out_port changes only on a commit; it never changes while out_valid=1 unless a commit occurs.
- STATUS overrun clear and a new overrun event in the same cycle: set wins, overrun=1.
- Reset mid-PEND drops the pending value; out_valid=0 on the reset edge.
- WIDTH<32: writedata upper bits are ignored; read-back upper bits are 0.

Decomposition:
- Shared package pio_out_pkg:
  - address constants ADDR_DATA=0, ADDR_CTRL=1, ADDR_STATUS=2, ADDR_OUT=3;
  - bit indices CTRL_COMMIT=0, CTRL_AUTO=1, STAT_VALID=0, STAT_OVERRUN=1;
  - FSM state typedef {IDLE, PEND}.
- One natural sub-module: pio_out_handshake. It holds the FSM, out_port, out_valid and overrun, with inputs commit, commit_data, out_ready and overrun_clr. The top keeps the register decode, staging, auto and readdata.

Test Plan:
- Reset: assert reset_n=0 one cycle during a DATA write of 0xABCDE -> readdata=0, out_port=0, out_valid=0; then read addr0 -> 0x00000.
- Manual commit: write DATA 0x12345, write CTRL 0x1, out_ready=0 -> out_port=0x12345 and out_valid=1 the cycle after the write; STATUS reads 0x1. Assert out_ready one cycle -> out_valid=0 next cycle.
- Auto commit: write CTRL 0x2, then DATA 0x0FFFF -> out_port=0x0FFFF and out_valid=1 one cycle later; CTRL reads 0x2.
- Overrun: commit 0x00001, out_ready=0, commit 0x00002 -> out_port=0x00002, STATUS=0x3. Write STATUS 0x2 -> STATUS=0x1.
- Simultaneous accept and commit: in PEND, out_ready=1 in the same cycle as a commit of 0x00055 -> out_valid stays 1, out_port=0x00055, overrun stays 0.
- Width masking: write DATA 0xFFFFFFFF -> addr0 reads 0x000FFFFF; after a commit, addr3 reads 0x000FFFFF.

Source files
------------

// File: rtl/pio_out_pkg.sv
// Shared constants and types for the HPS-to-fabric commit PIO.
package pio_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_OUT    = 2'd3;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int STAT_VALID   = 0;
  localparam int STAT_OVERRUN = 1;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

endpackage

// File: rtl/pio_phasor_out_commit_if.sv
// Avalon-MM slave bus plus the valid/ready output stream of the commit PIO.
interface pio_phasor_out_commit_if #(parameter int WIDTH = 20);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_port, out_valid
  );
endinterface

// File: rtl/pio_out_handshake.sv
// Valid/ready presentation of committed values with sticky overrun detection.
module pio_out_handshake
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             commit,
  input  logic [WIDTH-1:0] commit_data,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] out_port,
  output logic             out_valid,
  output logic             overrun
);

  state_t state;
  logic   overrun_set;

  // A commit landing on an unaccepted value drops it; set beats clear.
  assign overrun_set = commit && (state == PEND) && !out_ready;
  assign out_valid   = (state == PEND);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      out_port <= RESET_VALUE;
      overrun  <= 1'b0;
    end else begin
      if (commit) begin
        state    <= PEND;
        out_port <= commit_data;
      end else if (state == PEND && out_ready) begin
        state <= IDLE;
      end
      if (overrun_set)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/pio_phasor_out_commit.sv
// Avalon-MM output PIO: staging register, commit control and registered readback.
module pio_phasor_out_commit
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pio_phasor_out_commit_if.slave bus
);

  logic [WIDTH-1:0] staging;
  logic             auto;
  logic             wr, wr_data, wr_ctrl, wr_stat;
  logic             commit;
  logic [WIDTH-1:0] commit_data;
  logic [WIDTH-1:0] out_port;
  logic             out_valid;
  logic             overrun;
  logic [31:0]      rd_next;
  logic             unused_wd;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign wr      = bus.chipselect && !bus.write_n;
  assign wr_data = wr && (bus.address == ADDR_DATA);
  assign wr_ctrl = wr && (bus.address == ADDR_CTRL);
  assign wr_stat = wr && (bus.address == ADDR_STATUS);

  // Auto-commit forwards the incoming word, not the staging value it replaces.
  assign commit      = (wr_ctrl && bus.writedata[CTRL_COMMIT]) || (wr_data && auto);
  assign commit_data = wr_data ? bus.writedata[WIDTH-1:0] : staging;

  assign unused_wd = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      staging      <= RESET_VALUE;
      auto         <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (wr_data) staging <= bus.writedata[WIDTH-1:0];
      if (wr_ctrl) auto    <= bus.writedata[CTRL_AUTO];
      bus.readdata <= rd_next;
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:   rd_next = zext(staging);
      ADDR_CTRL:   rd_next[CTRL_AUTO] = auto;
      ADDR_STATUS: begin
        rd_next[STAT_VALID]   = out_valid;
        rd_next[STAT_OVERRUN] = overrun;
      end
      default:     rd_next = zext(out_port);
    endcase
  end

  pio_out_handshake #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_handshake (
    .clk         (clk),
    .reset_n     (reset_n),
    .commit      (commit),
    .commit_data (commit_data),
    .out_ready   (bus.out_ready),
    .overrun_clr (wr_stat && bus.writedata[STAT_OVERRUN]),
    .out_port    (out_port),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

  assign bus.out_port  = out_port;
  assign bus.out_valid = out_valid;

endmodule
